// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the WISC pipeline sequencing controller.
//   halt_state_e : halt FSM encoding (RUN / DRAIN / HALTED)
//   sb_entry_t   : one scoreboard entry {valid, destination reg, is_load}
//   NOP_INSTR    : encoding of the instruction used when a stage is bubbled
//   src_match()  : RAW compare of the ID sources against one entry
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } halt_state_e;

  typedef struct packed {
    logic       valid;
    logic [2:0] rd;
    logic       is_load;
  } sb_entry_t;

  localparam logic [15:0] NOP_INSTR = 16'h0800;
  localparam sb_entry_t   SB_BUBBLE = '{valid: 1'b0, rd: 3'd0, is_load: 1'b0};

  // True when the instruction in ID reads the register this entry will write.
  function automatic logic src_match(
    input sb_entry_t  e,
    input logic       id_valid,
    input logic [2:0] rs,
    input logic       rs_used,
    input logic [2:0] rt,
    input logic       rt_used
  );
    return e.valid & id_valid & ((rs_used & (rs == e.rd)) | (rt_used & (rt == e.rd)));
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Two-entry in-flight writer scoreboard (EX and MEM) with RAW hazard detect.
//   clk, rst          : clock, asynchronous active-low reset
//   freeze            : hold both entries (D-cache stall)
//   issue             : the ID instruction enters EX as a register writer
//   id_*              : ID source/destination fields
//   hazard            : ID must stall this cycle
//   sb_empty          : neither entry holds a writer
module hazard_scoreboard
  import pipe_ctrl_pkg::*;
#(
  parameter bit FWD_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       freeze,
  input  logic       issue,
  input  logic       id_valid,
  input  logic [2:0] id_rs,
  input  logic [2:0] id_rt,
  input  logic       id_rs_used,
  input  logic       id_rt_used,
  input  logic [2:0] id_wr_reg,
  input  logic       id_is_load,
  output logic       hazard,
  output logic       sb_empty
);

  sb_entry_t ex_reg, mem_reg, ex_next;
  logic      match_ex, match_mem;

  always_comb begin
    ex_next = SB_BUBBLE;
    if (issue) ex_next = '{valid: 1'b1, rd: id_wr_reg, is_load: id_is_load};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_reg  <= SB_BUBBLE;
      mem_reg <= SB_BUBBLE;
    end else if (!freeze) begin
      mem_reg <= ex_reg;
      ex_reg  <= ex_next;
    end
  end

  always_comb begin
    match_ex  = src_match(ex_reg, id_valid, id_rs, id_rs_used, id_rt, id_rt_used);
    match_mem = src_match(mem_reg, id_valid, id_rs, id_rs_used, id_rt, id_rt_used);
    // With forwarding only a load in EX cannot supply its data in time.
    if (FWD_EN) hazard = match_ex & ex_reg.is_load;
    else        hazard = match_ex | match_mem;
  end

  assign sb_empty = ~ex_reg.valid & ~mem_reg.valid;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage WISC core.
//   clk, rst             : clock, asynchronous active-low reset
//   id_*                 : decode-stage register use and control
//   fetch_busy, mem_busy : I-cache miss / D-cache stall
//   stall_if             : hold PC and IF/ID
//   stall_id             : inject a NOP into ID/EX
//   freeze               : hold ID/EX, EX/MEM, MEM/WB
//   flush_if_id          : replace IF/ID with a NOP
//   halt_done            : pipeline drained after HALT (registered)
//   stall_cnt            : saturating count of RUN-state stall cycles (registered)
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter bit          FWD_EN = 1'b1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [2:0]       id_rs,
  input  logic [2:0]       id_rt,
  input  logic             id_rs_used,
  input  logic             id_rt_used,
  input  logic             id_wr_en,
  input  logic [2:0]       id_wr_reg,
  input  logic             id_is_load,
  input  logic             id_flush_req,
  input  logic             id_halt,
  input  logic             fetch_busy,
  input  logic             mem_busy,
  output logic             stall_if,
  output logic             stall_id,
  output logic             freeze,
  output logic             flush_if_id,
  output logic             halt_done,
  output logic [CNT_W-1:0] stall_cnt
);

  halt_state_e      state_reg, state_next;
  logic             hazard, sb_empty, issue, halt_issue, in_run;
  logic             halt_done_reg;
  logic [CNT_W-1:0] stall_cnt_reg;

  hazard_scoreboard #(.FWD_EN(FWD_EN)) u_sb (
    .clk        (clk),
    .rst        (rst),
    .freeze     (freeze),
    .issue      (issue),
    .id_valid   (id_valid),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_rs_used (id_rs_used),
    .id_rt_used (id_rt_used),
    .id_wr_reg  (id_wr_reg),
    .id_is_load (id_is_load),
    .hazard     (hazard),
    .sb_empty   (sb_empty)
  );

  assign freeze = mem_busy;
  assign in_run = (state_reg == ST_RUN);

  // Freeze beats hazard beats flush. ID/EX is held (not bubbled) during a
  // freeze, so stall_id stays low. A flush lost to a stall is re-requested
  // by decode because the branch is still sitting in ID.
  always_comb begin
    stall_if    = 1'b0;
    stall_id    = 1'b0;
    flush_if_id = 1'b0;
    if (freeze) begin
      stall_if = 1'b1;
    end else if (!in_run || hazard) begin
      stall_if = 1'b1;
      stall_id = 1'b1;
    end else begin
      flush_if_id = id_flush_req | fetch_busy;
    end
  end

  assign issue      = id_valid & id_wr_en & ~stall_id & ~freeze & in_run;
  assign halt_issue = id_valid & id_halt  & ~stall_id & ~freeze & in_run;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_RUN:    if (halt_issue) state_next = ST_DRAIN;
      ST_DRAIN:  if (sb_empty && !mem_busy) state_next = ST_HALTED;
      ST_HALTED: state_next = ST_HALTED;
      default:   state_next = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= ST_RUN;
      halt_done_reg <= 1'b0;
      stall_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      halt_done_reg <= (state_next == ST_HALTED);
      if (in_run && stall_if && (stall_cnt_reg != {CNT_W{1'b1}}))
        stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
    end
  end

  assign halt_done = halt_done_reg;
  assign stall_cnt = stall_cnt_reg;

endmodule
